// File: rtl/tia_hsync_counter_if.sv
// Control and timing-pulse bundle between the TIA line-timing logic and the hsync counter.
interface tia_hsync_counter_if;
    localparam int unsigned HW = 6;

    logic          clk_en;
    logic          rsync;
    logic          hmove_late;
    logic [HW-1:0] hcount;
    logic          shb;
    logic          shs;
    logic          rhs;
    logic          rcb;
    logic          rhb;

    modport master (
        output clk_en, rsync, hmove_late,
        input  hcount, shb, shs, rhs, rcb, rhb
    );

    modport slave (
        input  clk_en, rsync, hmove_late,
        output hcount, shb, shs, rhs, rcb, rhb
    );
endinterface

// File: rtl/tia_hsync_counter.sv
// TIA horizontal sync counter: 6-bit LFSR wrapping every 57 enabled steps,
// with registered one-clock decode pulses for HBLANK, HSYNC and colour burst.
module tia_hsync_counter #(
    parameter int unsigned SHS_COUNT  = 4,
    parameter int unsigned RHS_COUNT  = 8,
    parameter int unsigned RCB_COUNT  = 12,
    parameter int unsigned RHB_COUNT  = 16,
    parameter int unsigned LRHB_COUNT = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    tia_hsync_counter_if.slave   bus
);
    localparam int unsigned HW         = 6;
    localparam int unsigned LINE_STEPS = 57;

    function automatic logic [HW-1:0] lfsr_next(input logic [HW-1:0] s);
        return {~(s[0] ^ s[1]), s[HW-1:1]};
    endfunction

    // LFSR value reached k shifts after the all-zero state.
    function automatic logic [HW-1:0] lfsr_at(input int unsigned k);
        logic [HW-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < k; i++) begin
            s = lfsr_next(s);
        end
        return s;
    endfunction

    localparam logic [HW-1:0] S_LAST = lfsr_at(LINE_STEPS - 1);
    localparam logic [HW-1:0] S_SHS  = lfsr_at(SHS_COUNT);
    localparam logic [HW-1:0] S_RHS  = lfsr_at(RHS_COUNT);
    localparam logic [HW-1:0] S_RCB  = lfsr_at(RCB_COUNT);
    localparam logic [HW-1:0] S_RHB  = lfsr_at(RHB_COUNT);
    localparam logic [HW-1:0] S_LRHB = lfsr_at(LRHB_COUNT);

    logic [HW-1:0] hcount_q, hcount_d;
    logic          shb_q, shb_d;
    logic          shs_q, shs_d;
    logic          rhs_q, rhs_d;
    logic          rcb_q, rcb_d;
    logic          rhb_q, rhb_d;

    // Next state and decode of the state being entered; pulses only on an update.
    always_comb begin
        hcount_d = hcount_q;
        shb_d    = 1'b0;
        shs_d    = 1'b0;
        rhs_d    = 1'b0;
        rcb_d    = 1'b0;
        rhb_d    = 1'b0;
        if (bus.rsync) begin
            hcount_d = '0;
            shb_d    = 1'b1;
        end else if (bus.clk_en) begin
            if (hcount_q == S_LAST) begin
                hcount_d = '0;
                shb_d    = 1'b1;
            end else begin
                hcount_d = lfsr_next(hcount_q);
            end
            shs_d = (hcount_d == S_SHS);
            rhs_d = (hcount_d == S_RHS);
            rcb_d = (hcount_d == S_RCB);
            rhb_d = bus.hmove_late ? (hcount_d == S_LRHB) : (hcount_d == S_RHB);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcount_q <= '0;
            shb_q    <= 1'b0;
            shs_q    <= 1'b0;
            rhs_q    <= 1'b0;
            rcb_q    <= 1'b0;
            rhb_q    <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            shb_q    <= shb_d;
            shs_q    <= shs_d;
            rhs_q    <= rhs_d;
            rcb_q    <= rcb_d;
            rhb_q    <= rhb_d;
        end
    end

    assign bus.hcount = hcount_q;
    assign bus.shb    = shb_q;
    assign bus.shs    = shs_q;
    assign bus.rhs    = rhs_q;
    assign bus.rcb    = rcb_q;
    assign bus.rhb    = rhb_q;
endmodule

// File: doc/tia_hsync_counter.md
Name: tia_hsync_counter

Overview:
- Horizontal sync counter for the TIA line timing, built as a 6-bit polynomial (LFSR) counter.
- Advances once per horizontal phase enable and wraps every 57 counts, one scanline.
- Decodes fixed counts into single-cycle set/reset pulses that drive the downstream sr latches: HBLANK, HSYNC and colour burst.

Parameters:
- SHS_COUNT, 4, step index at which the set-HSYNC pulse fires.
- RHS_COUNT, 8, step index at which the reset-HSYNC pulse fires.
- RCB_COUNT, 12, step index at which the reset-colour-burst pulse fires.
- RHB_COUNT, 16, step index at which the normal reset-HBLANK pulse fires.
- LRHB_COUNT, 18, step index at which the late reset-HBLANK pulse fires (HMOVE).

Ports:
- clock  input  1  system clock; all state updates on its posedge.
- reset  input  1  synchronous, active-high reset.
- clk_en  input  1  phase enable; the counter advances only on cycles where this is 1.
- rsync  input  1  synchronous line restart (RSYNC strobe).
- hmove_late  input  1  level; selects late HBLANK end (LRHB_COUNT instead of RHB_COUNT).
- hcount  output  6  current LFSR state.
- shb  output  1  start-HBLANK pulse (line wrap).
- shs  output  1  set-HSYNC pulse.
- rhs  output  1  reset-HSYNC pulse.
- rcb  output  1  reset-colour-burst pulse.
- rhb  output  1  reset-HBLANK pulse.

Behaviour:
- LFSR step: next = {x, hcount[5:1]}, where x = hcount[0] XNOR hcount[1]. Bits are written [5:0].
- Step index k means the state reached k shifts after 000000 (S0).
  - S1 = 100000, S2 = 110000, S3 = 111000, S4 = 111100, S5 = 111110, S6 = 011111.
- Decode constants are the LFSR values for the parameter indices. Derive them at elaboration or hardcode them from the defaults. No binary shadow counter is permitted.
- Wrap: if clk_en=1 and hcount == S56, next state is S0, not the LFSR successor. Line length is exactly 57 enabled steps.
- The lockup state 111111 is never reached from S0; no recovery logic is required.
- Priority per cycle: reset > rsync > clk_en advance > hold.
  - reset=1: hcount <= 000000; all pulse outputs <= 0.
  - rsync=1 (no reset): hcount <= 000000 regardless of clk_en; shb pulses next cycle.
  - clk_en=1: advance or wrap.
  - clk_en=0 and rsync=0: hcount holds; no pulses.
- Pulses are registered and asserted for exactly one clock. The pulse appears in the cycle after the update that moved hcount into the decoded state. Rules per pulse:
  - shb: on wrap into S0, or on rsync. Not on reset.
  - shs / rhs / rcb: on entry into S[SHS_COUNT] / S[RHS_COUNT] / S[RCB_COUNT].
  - rhb: on entry into S[RHB_COUNT] if hmove_late=0, else on entry into S[LRHB_COUNT]. hmove_late is sampled in the same cycle as the entering update.
- The counter holding in a decoded state while clk_en=0 produces no repeated pulse.
- Pulse outputs are mutually exclusive by construction; at most one is high per cycle.
- Reset mid-line: counter returns to S0 silently. The next pulse is shs after 4 enabled steps.

Test Plan:
- Reset, then 3 cycles with clk_en=1 -> hcount = 100000, 110000, 111000; all pulses 0.
- clk_en=1 continuously for 200 cycles -> shb high every 57 cycles. shs exactly 4 cycles after each shb, rhs 8 after, rcb 12 after, rhb 16 after. Each pulse lasts 1 cycle.
- clk_en=1 one cycle in four -> pulses spaced 4x the above (shb period 228 clocks). Each pulse still lasts 1 clock. hcount stable between enables.
- hmove_late=1 for a full line -> rhb 18 enables after shb, none at 16. hmove_late toggled to 0 at step 17 -> no rhb that line.
- rsync=1 at step 30 with clk_en=0 -> hcount = 000000 next cycle, shb next cycle, shs after 4 further enables.
- reset asserted at step 10 together with rsync and clk_en -> hcount = 000000, no shb, all outputs 0. shs after 4 enables following reset release.
